// File: rtl/rr_arb8_dec.sv
// ---------------------------------------------------------------------------
// rr_arb8_dec
// Round-robin arbiter that shares one 3-to-8 decoded resource among eight
// requesters. The grant is presented both as {gnt_en, gnt_idx}, which is the
// {en, in} pair a dec3to8 consumes, and as the equivalent one-hot vector.
// A hold limit keeps any single requester from monopolising the resource.
//
// Parameters
//   MAX_HOLD  maximum consecutive cycles a grant may be held (1..255)
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   request vector, bit i belongs to requester i
//   done     in   owner releases the resource (only looked at while granted)
//   gnt_idx  out  index of the granted requester (decoder 'in')
//   gnt_en   out  grant valid (decoder 'en')
//   gnt      out  one-hot grant, all zero when gnt_en is low
//   tmo      out  one-cycle pulse: the previous grant ended by hold timeout
// ---------------------------------------------------------------------------
module rr_arb8_dec #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] gnt_idx,
  output logic       gnt_en,
  output logic [7:0] gnt,
  output logic       tmo
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;

  logic [2:0] pick_idx;
  logic       pick_valid;
  logic [2:0] cand;

  logic       rel_done;
  logic       rel_drop;
  logic       rel_limit;
  logic       release_now;

  // Scan from ptr upward with wraparound. The loop runs from the farthest
  // candidate back to ptr so the closest requesting index wins.
  always_comb begin
    pick_idx   = ptr;
    pick_valid = 1'b0;
    cand       = '0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) begin
        pick_idx   = cand;
        pick_valid = 1'b1;
      end
    end
  end

  // Release causes, listed by priority: done, request drop, hold limit.
  always_comb begin
    rel_done    = done;
    rel_drop    = ~req[gnt_idx];
    rel_limit   = (hold_cnt == 8'(MAX_HOLD - 1));
    release_now = rel_done | rel_drop | rel_limit;
  end

  // Two-state controller. Every release passes through IDLE for one cycle,
  // which is what spaces consecutive grants apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      gnt_idx  <= 3'd0;
      hold_cnt <= 8'd0;
      tmo      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo <= 1'b0;
          if (pick_valid) begin
            gnt_idx  <= pick_idx;
            hold_cnt <= 8'd0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          hold_cnt <= hold_cnt + 8'd1;
          if (release_now) begin
            state <= IDLE;
            ptr   <= gnt_idx + 3'd1;
            tmo   <= rel_limit & ~rel_done & ~rel_drop;
          end else begin
            tmo <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tmo   <= 1'b0;
        end
      endcase
    end
  end

  // Outputs decode only registered state, so there is no req->gnt path and
  // the async reset clears them immediately.
  always_comb begin
    gnt_en = (state == GRANT);
    gnt    = gnt_en ? (8'd1 << gnt_idx) : 8'h00;
  end

endmodule

// File: tb/tb_rr_arb8_dec.sv
// ---------------------------------------------------------------------------
// tb_rr_arb8_dec
// Directed bench for rr_arb8_dec with MAX_HOLD=4. Inputs change and outputs
// are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_rr_arb8_dec;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [2:0] gnt_idx;
  logic       gnt_en;
  logic [7:0] gnt;
  logic       tmo;

  int err_cnt;
  int chk_cnt;

  rr_arb8_dec #(.MAX_HOLD(4)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt_idx (gnt_idx),
    .gnt_en  (gnt_en),
    .gnt     (gnt),
    .tmo     (tmo)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Check the whole grant bundle for an active grant to idx.
  task automatic checkGrant(input string tag, input logic [2:0] idx);
    logic [7:0] oh;
    oh = 8'd1 << idx;
    checkOutput({tag, "_en"},  32'(gnt_en),  32'd1);
    checkOutput({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
    checkOutput({tag, "_gnt"}, 32'(gnt),     32'(oh));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_en"},  32'(gnt_en), 32'd0);
    checkOutput({tag, "_gnt"}, 32'(gnt),    32'h00);
  endtask

  initial begin
    logic [2:0] exp_idx;
    err_cnt = 0;
    chk_cnt = 0;
    rst_n   = 1'b0;
    req     = 8'hFF;
    done    = 1'b0;

    // Reset state with requests pending and clock running.
    applyStimulus();
    applyStimulus();
    checkIdle("rst");
    checkOutput("rst_idx", 32'(gnt_idx), 32'd0);
    checkOutput("rst_tmo", 32'(tmo), 32'd0);

    // Single request, done release, then next grant starts after idx 5.
    req   = 8'h00;
    rst_n = 1'b1;
    applyStimulus();
    checkIdle("no_req");
    req = 8'h20;
    applyStimulus();
    checkGrant("req20", 3'd5);
    done = 1'b1;
    applyStimulus();
    checkIdle("done_rel");
    checkOutput("done_rel_tmo", 32'(tmo), 32'd0);
    done = 1'b0;
    req  = 8'hFF;
    applyStimulus();
    checkGrant("after5", 3'd6);

    // Fresh reset, then full rotation with done held: 0..7,0 with idle gaps.
    rst_n = 1'b0;
    #1;
    checkIdle("rst2");
    applyStimulus();
    rst_n = 1'b1;
    done  = 1'b1;
    exp_idx = 3'd0;
    for (int k = 0; k < 9; k++) begin
      applyStimulus();
      checkGrant($sformatf("rr%0d", k), exp_idx);
      applyStimulus();
      checkIdle($sformatf("rr_gap%0d", k));
      exp_idx = exp_idx + 3'd1;
    end

    // Wraparound: grant 7, grant 5 (ptr=6), then req=03 gives 0 then 1.
    req = 8'h80;
    applyStimulus();
    checkGrant("wrap7", 3'd7);
    applyStimulus();
    req = 8'h20;
    applyStimulus();
    checkGrant("wrap5", 3'd5);
    applyStimulus();
    req = 8'h03;
    applyStimulus();
    checkGrant("wrap_a", 3'd0);
    applyStimulus();
    checkIdle("wrap_gap");
    applyStimulus();
    checkGrant("wrap_b", 3'd1);
    applyStimulus();

    // Hold-limit timeout: 4 granted cycles, tmo in the idle cycle, re-grant.
    done = 1'b0;
    req  = 8'h04;
    for (int c = 0; c < 4; c++) begin
      applyStimulus();
      checkGrant($sformatf("hold%0d", c), 3'd2);
      checkOutput($sformatf("hold%0d_tmo", c), 32'(tmo), 32'd0);
    end
    applyStimulus();
    checkIdle("tmo_gap");
    checkOutput("tmo_pulse", 32'(tmo), 32'd1);
    applyStimulus();
    checkGrant("regrant", 3'd2);
    checkOutput("regrant_tmo", 32'(tmo), 32'd0);

    // done on the timeout cycle wins: release without tmo.
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkGrant("last_hold", 3'd2);
    done = 1'b1;
    applyStimulus();
    checkIdle("done_at_lim");
    checkOutput("done_at_lim_tmo", 32'(tmo), 32'd0);
    done = 1'b0;

    // Request drop ends the grant without tmo.
    applyStimulus();
    checkGrant("drop_g", 3'd2);
    req = 8'h00;
    applyStimulus();
    checkIdle("drop_rel");
    checkOutput("drop_tmo", 32'(tmo), 32'd0);

    // Async reset mid-grant, then ptr back at 0.
    req = 8'h08;
    applyStimulus();
    checkGrant("pre_rst", 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdle("async_rst");
    req = 8'hFF;
    applyStimulus();
    rst_n = 1'b1;
    applyStimulus();
    checkGrant("post_rst", 3'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
